rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter_if.sv | 29 ++
 rtl/rom_arbiter.sv | 116 +++++++++++
 tb/tb_rom_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_arbiter_if.sv
// Bundle between rom_arbiter, its read requesters, the loader and the shared block RAM.
// Handshake: req[i] is a level held by requester i; ack[i] is a one-cycle pulse (no back-pressure) marking the cycle its rsp_data byte takes a new value.
interface rom_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [12*NUM_REQ-1:0] req_addr;
    logic [NUM_REQ-1:0]    ack;
    logic [8*NUM_REQ-1:0]  rsp_data;
    logic [11:0]           mem_addr;
    logic [7:0]            mem_data;
    logic                  mem_we;
    logic [7:0]            mem_wdata;
    logic                  ld_we;
    logic [11:0]           ld_addr;
    logic [7:0]            ld_data;
    logic                  ld_ack;
    logic                  busy;

    modport slave (
        input  req, req_addr, mem_data, ld_we, ld_addr, ld_data,
        output ack, rsp_data, mem_addr, mem_we, mem_wdata, ld_ack, busy
    );

    modport master (
        output req, req_addr, mem_data, ld_we, ld_addr, ld_data,
        input  ack, rsp_data, mem_addr, mem_we, mem_wdata, ld_ack, busy
    );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one block RAM between NUM_REQ readers, one read per cycle, latency 1.
// Defining ROM_ARBITER_LOADER_EN enables the loader write port, which preempts reads.
module rom_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic         sysclk,
    input  logic         poc,
    rom_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          pend_q;
    logic [PW-1:0] pend_id_q;
    logic [11:0]   addr_q;
    logic [11:0]   addr_d;
    logic [7:0]    rsp_q [NUM_REQ];
    logic          ld_ack_q;
    logic          wr_now;
    logic          grant_vld;
    logic [PW-1:0] grant_id;
    logic [PW-1:0] idx;

`ifdef ROM_ARBITER_LOADER_EN
    assign wr_now = bus.ld_we & ~poc;
`else
    logic ld_unused;
    assign ld_unused = ^{bus.ld_we, bus.ld_addr, bus.ld_data};
    assign wr_now    = 1'b0;
`endif

    // The requester whose read is still in flight is skipped so it cannot double-issue.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_vld && bus.req[idx] && !(pend_q && pend_id_q == idx)) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
        if (poc || wr_now) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = PW'((int'(grant_id) + 1) % NUM_REQ);
        end
    end

    always_comb begin
        addr_d        = addr_q;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
`ifdef ROM_ARBITER_LOADER_EN
        if (wr_now) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = bus.ld_data;
            addr_d        = bus.ld_addr;
        end
`endif
        if (grant_vld) begin
            addr_d = bus.req_addr[12*int'(grant_id) +: 12];
        end
        bus.mem_addr = poc ? 12'h000 : addr_d;
    end

    // During the ack cycle the byte comes straight from the RAM output; afterwards from rsp_q.
    always_comb begin
        bus.ack      = '0;
        bus.rsp_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!poc) begin
                if (pend_q && pend_id_q == PW'(i)) begin
                    bus.ack[i]             = 1'b1;
                    bus.rsp_data[8*i +: 8] = bus.mem_data;
                end else begin
                    bus.rsp_data[8*i +: 8] = rsp_q[i];
                end
            end
        end
    end

    assign bus.busy   = ~poc & (pend_q | (|bus.req));
    assign bus.ld_ack = ld_ack_q;

    always_ff @(posedge sysclk) begin
        if (poc) begin
            ptr_q     <= '0;
            pend_q    <= 1'b0;
            pend_id_q <= '0;
            addr_q    <= '0;
            ld_ack_q  <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_q[i] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            pend_q   <= grant_vld;
            addr_q   <= addr_d;
            ld_ack_q <= wr_now;
            if (grant_vld) begin
                pend_id_q <= grant_id;
            end
            if (pend_q) begin
                rsp_q[pend_id_q] <= bus.mem_data;
            end
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
// Runs the loader checks matching whether ROM_ARBITER_LOADER_EN is defined.
module tb_rom_arbiter;
    localparam int N = 4;

    logic sysclk = 1'b0;
    logic poc;
    always #5 sysclk = ~sysclk;

    rom_arbiter_if #(.NUM_REQ(N)) bus ();
    rom_arbiter #(.NUM_REQ(N)) dut (.sysclk(sysclk), .poc(poc), .bus(bus));

    // Synchronous read-first block RAM.
    logic [7:0] ram  [4096];
    logic [7:0] gold [4096];
    always @(posedge sysclk) begin
        bus.mem_data <= ram[bus.mem_addr];
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state: exp_q holds the one in-flight read as {id, byte}.
    logic [9:0]     exp_q[$];
    int             m_ptr;
    logic [11:0]    m_last;
    logic [7:0]     m_rsp [N];
    logic           m_ld;
    logic [N-1:0]   exp_ack;
    logic [8*N-1:0] exp_rsp;
    logic [11:0]    exp_addr;
    logic           exp_we;
    logic [7:0]     exp_wdata;
    logic           exp_ld_ack;
    logic           exp_busy;

    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [11:0] a);
        bus.req_addr[12*i +: 12] = a;
    endtask

    task automatic do_reset();
        poc       = 1'b1;
        bus.req   = '0;
        bus.ld_we = 1'b0;
        cyc();
        cyc();
        poc = 1'b0;
    endtask

    task automatic model_cycle();
        logic [9:0]  e;
        logic [11:0] a;
        bit          has_pend;
        bit          did_write;
        int          pid;
        if (poc) begin
            exp_ack = '0; exp_rsp = '0; exp_addr = '0; exp_we = 1'b0;
            exp_wdata = '0; exp_ld_ack = 1'b0; exp_busy = 1'b0;
            exp_q.delete();
            m_ptr = 0; m_last = '0; m_ld = 1'b0;
            for (int i = 0; i < N; i++) m_rsp[i] = '0;
            return;
        end
        exp_ld_ack = m_ld;
        m_ld       = 1'b0;
        exp_ack    = '0;
        has_pend   = 0;
        pid        = 0;
        if (exp_q.size() > 0) begin
            e        = exp_q.pop_front();
            has_pend = 1;
            pid      = int'(e[9:8]);
            exp_ack[pid] = 1'b1;
            m_rsp[pid]   = e[7:0];
        end
        exp_busy  = has_pend || (bus.req != '0);
        exp_we    = 1'b0;
        exp_wdata = '0;
        exp_addr  = m_last;
        did_write = 0;
`ifdef ROM_ARBITER_LOADER_EN
        if (bus.ld_we) begin
            exp_we    = 1'b1;
            exp_wdata = bus.ld_data;
            exp_addr  = bus.ld_addr;
            gold[bus.ld_addr] = bus.ld_data;
            m_ld      = 1'b1;
            did_write = 1;
        end
`endif
        if (!did_write) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (bus.req[i] && !(has_pend && pid == i)) begin
                    a        = bus.req_addr[12*i +: 12];
                    exp_addr = a;
                    exp_q.push_back({2'(i), gold[a]});
                    m_ptr    = (i + 1) % N;
                    break;
                end
            end
        end
        m_last = exp_addr;
        for (int i = 0; i < N; i++) exp_rsp[8*i +: 8] = m_rsp[i];
    endtask

    task automatic test_reset();
        poc       = 1'b1;
        bus.req   = '1;
        bus.ld_we = 1'b1;
        bus.ld_addr = 12'h0AA;
        bus.ld_data = 8'h55;
        for (int i = 0; i < N; i++) set_addr(i, 12'($urandom_range(1, 4095)));
        for (int r = 0; r < 2; r++) begin
            cyc();
            @(negedge sysclk);
            checks++; if (bus.ack !== '0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus.ack); end
            checks++; if (bus.rsp_data !== '0) begin errors++; $display("FAIL reset_rsp: got %h expected 0", bus.rsp_data); end
            checks++; if (bus.mem_addr !== 12'h000) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
            checks++; if (bus.mem_we !== 1'b0 || bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_we: got %b/%h expected 0/00", bus.mem_we, bus.mem_wdata); end
            checks++; if (bus.ld_ack !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_ld_ack_busy: got %b/%b expected 0/0", bus.ld_ack, bus.busy); end
        end
        bus.ld_we = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        bus.req = 4'b0100;
        for (int i = 0; i < N; i++) set_addr(i, 12'($urandom_range(0, 4095)));
        set_addr(2, 12'h123);
        @(negedge sysclk);
        checks++; if (bus.mem_addr !== 12'h123) begin errors++; $display("FAIL single_mem_addr: got %h expected 123", bus.mem_addr); end
        cyc();
        bus.req = '0;
        set_addr(2, 12'($urandom_range(0, 4095)));
        @(negedge sysclk);
        checks++; if (bus.ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b expected 0100", bus.ack); end
        checks++; if (bus.rsp_data[23:16] !== 8'hA5) begin errors++; $display("FAIL single_rsp: got %h expected a5", bus.rsp_data[23:16]); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
        cyc();
        @(negedge sysclk);
        checks++; if (bus.ack !== 4'b0000 || bus.rsp_data[23:16] !== 8'hA5) begin errors++; $display("FAIL single_hold: got %b/%h expected 0000/a5", bus.ack, bus.rsp_data[23:16]); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_contention();
        logic [11:0] a [N];
        int id;
        do_reset();
        bus.req = '1;
        for (int i = 0; i < N; i++) begin
            a[i] = 12'($urandom_range(0, 4095));
            set_addr(i, a[i]);
        end
        @(negedge sysclk);
        checks++; if (bus.ack !== '0 || bus.mem_addr !== a[0]) begin errors++; $display("FAIL contend_first: got %b/%h expected 0000/%h", bus.ack, bus.mem_addr, a[0]); end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            @(negedge sysclk);
            id = (k - 1) % N;
            checks++; if (bus.ack !== N'(1 << id)) begin errors++; $display("FAIL contend_ack[%0d]: got %b expected %b", k, bus.ack, N'(1 << id)); end
            checks++; if (bus.rsp_data[8*id +: 8] !== gold[a[id]]) begin errors++; $display("FAIL contend_rsp[%0d]: got %h expected %h", k, bus.rsp_data[8*id +: 8], gold[a[id]]); end
            checks++; if (bus.mem_addr !== a[k % N]) begin errors++; $display("FAIL contend_addr[%0d]: got %h expected %h", k, bus.mem_addr, a[k % N]); end
        end
        cyc();
        bus.req = '0;
    endtask

    task automatic test_addr_change();
        do_reset();
        bus.req = 4'b0010;
        set_addr(1, 12'h123);
        @(negedge sysclk);
        cyc();
        set_addr(1, 12'h456);
        @(negedge sysclk);
        checks++; if (bus.ack !== 4'b0010 || bus.rsp_data[15:8] !== 8'hA5) begin errors++; $display("FAIL addr_change_rsp: got %b/%h expected 0010/a5", bus.ack, bus.rsp_data[15:8]); end
        checks++; if (bus.mem_addr !== 12'h123) begin errors++; $display("FAIL addr_change_hold: got %h expected 123", bus.mem_addr); end
        cyc();
        @(negedge sysclk);
        checks++; if (bus.ack !== 4'b0000 || bus.mem_addr !== 12'h456) begin errors++; $display("FAIL addr_change_rearb: got %b/%h expected 0000/456", bus.ack, bus.mem_addr); end
        cyc();
        bus.req = '0;
        @(negedge sysclk);
        checks++; if (bus.ack !== 4'b0010 || bus.rsp_data[15:8] !== 8'h5A) begin errors++; $display("FAIL addr_change_second: got %b/%h expected 0010/5a", bus.ack, bus.rsp_data[15:8]); end
        cyc();
    endtask

    task automatic test_reset_mid();
        logic [11:0] a0;
        do_reset();
        bus.req = 4'b0100;
        set_addr(2, 12'h456);
        cyc();
        bus.req = '0;
        @(negedge sysclk);
        checks++; if (bus.ack !== 4'b0100 || bus.rsp_data[23:16] !== 8'h5A) begin errors++; $display("FAIL midrst_pre: got %b/%h expected 0100/5a", bus.ack, bus.rsp_data[23:16]); end
        cyc();
        bus.req = 4'b0100;
        set_addr(2, 12'h123);
        cyc();
        poc     = 1'b1;
        bus.req = '1;
        a0      = 12'($urandom_range(0, 4095));
        set_addr(0, a0);
        @(negedge sysclk);
        checks++; if (bus.ack !== '0 || bus.rsp_data !== '0) begin errors++; $display("FAIL midrst_during: got %b/%h expected 0/0", bus.ack, bus.rsp_data); end
        cyc();
        poc = 1'b0;
        @(negedge sysclk);
        checks++; if (bus.ack !== '0 || bus.rsp_data[23:16] !== 8'h00) begin errors++; $display("FAIL midrst_discard: got %b/%h expected 0/00", bus.ack, bus.rsp_data[23:16]); end
        checks++; if (bus.mem_addr !== a0) begin errors++; $display("FAIL midrst_grant0_addr: got %h expected %h", bus.mem_addr, a0); end
        cyc();
        @(negedge sysclk);
        checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL midrst_grant0_ack: got %b expected 0001", bus.ack); end
        bus.req = '0;
        cyc();
    endtask

    task automatic test_loader();
`ifdef ROM_ARBITER_LOADER_EN
        logic [11:0] a [N];
        do_reset();
        bus.ld_we = 1'b1; bus.ld_addr = 12'h7FF; bus.ld_data = 8'h3C;
        bus.req = 4'b0010;
        set_addr(1, 12'h7FF);
        @(negedge sysclk);
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 12'h7FF || bus.mem_wdata !== 8'h3C) begin errors++; $display("FAIL loader_write: got %b/%h/%h expected 1/7ff/3c", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.ack !== '0) begin errors++; $display("FAIL loader_no_ack: got %b expected 0000", bus.ack); end
        cyc();
        bus.ld_we = 1'b0;
        gold[12'h7FF] = 8'h3C;
        @(negedge sysclk);
        checks++; if (bus.ld_ack !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL loader_ld_ack: got %b/%b expected 1/0", bus.ld_ack, bus.mem_we); end
        checks++; if (bus.mem_addr !== 12'h7FF) begin errors++; $display("FAIL loader_read_issue: got %h expected 7ff", bus.mem_addr); end
        cyc();
        bus.req = '0;
        @(negedge sysclk);
        checks++; if (bus.ack !== 4'b0010 || bus.rsp_data[15:8] !== 8'h3C) begin errors++; $display("FAIL loader_readback: got %b/%h expected 0010/3c", bus.ack, bus.rsp_data[15:8]); end
        checks++; if (bus.ld_ack !== 1'b0) begin errors++; $display("FAIL loader_ld_ack_pulse: got %b expected 0", bus.ld_ack); end
        // Stall during full contention must not move the round-robin pointer.
        do_reset();
        bus.req = '1;
        for (int i = 0; i < N; i++) begin
            a[i] = 12'($urandom_range(0, 4095));
            set_addr(i, a[i]);
        end
        bus.ld_we = 1'b1; bus.ld_addr = 12'($urandom_range(0, 4095)); bus.ld_data = 8'($urandom);
        @(negedge sysclk);
        checks++; if (bus.mem_we !== 1'b1 || bus.ack !== '0) begin errors++; $display("FAIL stall_write: got %b/%b expected 1/0000", bus.mem_we, bus.ack); end
        cyc();
        gold[bus.ld_addr] = bus.ld_data;
        bus.ld_we = 1'b0;
        @(negedge sysclk);
        checks++; if (bus.mem_addr !== a[0]) begin errors++; $display("FAIL stall_order: got %h expected %h", bus.mem_addr, a[0]); end
        for (int k = 0; k < 2; k++) begin
            cyc();
            @(negedge sysclk);
            checks++; if (bus.ack !== N'(1 << k) || bus.rsp_data[8*k +: 8] !== gold[a[k]]) begin errors++; $display("FAIL stall_ack[%0d]: got %b/%h expected %b/%h", k, bus.ack, bus.rsp_data[8*k +: 8], N'(1 << k), gold[a[k]]); end
        end
        bus.req = '0;
        cyc();
`else
        do_reset();
        bus.ld_we = 1'b1; bus.ld_addr = 12'h7FF; bus.ld_data = 8'h3C;
        bus.req = 4'b0010;
        set_addr(1, 12'h7FF);
        @(negedge sysclk);
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL noload_we: got %b/%h expected 0/00", bus.mem_we, bus.mem_wdata); end
        checks++; if (bus.mem_addr !== 12'h7FF) begin errors++; $display("FAIL noload_read_issue: got %h expected 7ff", bus.mem_addr); end
        cyc();
        bus.req = '0;
        @(negedge sysclk);
        checks++; if (bus.ld_ack !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL noload_ld_ack: got %b/%b expected 0/0", bus.ld_ack, bus.mem_we); end
        checks++; if (bus.ack !== 4'b0010 || bus.rsp_data[15:8] !== 8'hC3) begin errors++; $display("FAIL noload_read: got %b/%h expected 0010/c3", bus.ack, bus.rsp_data[15:8]); end
        bus.ld_we = 1'b0;
        cyc();
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            poc = (c == 0) ? 1'b1 : ($urandom_range(0, 49) == 0);
            bus.req = N'($urandom);
            for (int i = 0; i < N; i++) set_addr(i, 12'($urandom_range(0, 4095)));
            bus.ld_we   = ($urandom_range(0, 7) == 0);
            bus.ld_addr = 12'($urandom_range(0, 4095));
            bus.ld_data = 8'($urandom);
            model_cycle();
            @(negedge sysclk);
            checks++; if (bus.ack !== exp_ack) begin errors++; $display("FAIL rand_ack[%0d]: got %b expected %b", c, bus.ack, exp_ack); end
            checks++; if ($countones(bus.ack) > 1) begin errors++; $display("FAIL rand_onehot[%0d]: got %b expected at most one bit", c, bus.ack); end
            checks++; if (bus.rsp_data !== exp_rsp) begin errors++; $display("FAIL rand_rsp[%0d]: got %h expected %h", c, bus.rsp_data, exp_rsp); end
            checks++; if (bus.mem_addr !== exp_addr) begin errors++; $display("FAIL rand_mem_addr[%0d]: got %h expected %h", c, bus.mem_addr, exp_addr); end
            checks++; if (bus.mem_we !== exp_we || bus.mem_wdata !== exp_wdata) begin errors++; $display("FAIL rand_mem_we[%0d]: got %b/%h expected %b/%h", c, bus.mem_we, bus.mem_wdata, exp_we, exp_wdata); end
            checks++; if (bus.ld_ack !== exp_ld_ack) begin errors++; $display("FAIL rand_ld_ack[%0d]: got %b expected %b", c, bus.ld_ack, exp_ld_ack); end
            checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL rand_busy[%0d]: got %b expected %b", c, bus.busy, exp_busy); end
            cyc();
        end
        bus.req   = '0;
        bus.ld_we = 1'b0;
    endtask

    initial begin
        poc          = 1'b1;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.ld_we    = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        ram[12'h123] = 8'hA5;
        ram[12'h456] = 8'h5A;
        ram[12'h7FF] = 8'hC3;
        for (int i = 0; i < 4096; i++) gold[i] = ram[i];
        test_reset();
        test_single_read();
        test_contention();
        test_addr_change();
        test_reset_mid();
        test_loader();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
